// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed 8-digit seven-segment scan: debounces the scan,
// decodes each digit, publishes one snapshot per frame and classifies the digit-0 trend.
module seg_scan_decoder #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  an_in,
    output logic [31:0] digits,
    output logic [7:0]  digit_valid,
    output logic        frame_done,
    output logic [1:0]  dir,
    output logic        seg_err,
    output logic        stale
);

    localparam int unsigned CntW  = $clog2(SETTLE + 1);
    localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

    localparam logic [CntW-1:0]  SettleMax  = CntW'(SETTLE);
    localparam logic [CntW-1:0]  SettleLast = CntW'(SETTLE - 1);
    localparam logic [IdleW-1:0] IdleMax    = IdleW'(TIMEOUT);

    // {illegal, nibble}: blank maps to F without error, anything unknown to E with error.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h40:   res = 5'h00;
            7'h79:   res = 5'h01;
            7'h24:   res = 5'h02;
            7'h30:   res = 5'h03;
            7'h19:   res = 5'h04;
            7'h12:   res = 5'h05;
            7'h02:   res = 5'h06;
            7'h78:   res = 5'h07;
            7'h00:   res = 5'h08;
            7'h10:   res = 5'h09;
            7'h7F:   res = 5'h0F;
            default: res = 5'h1E;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] trend(input logic [3:0] n, input logic [3:0] p,
                                         input logic ok);
        logic [3:0] up;
        logic [3:0] down;
        logic [1:0] res;
        up   = (p == 4'd9) ? 4'd0 : p + 4'd1;
        down = (p == 4'd0) ? 4'd9 : p - 4'd1;
        if (!ok || n > 4'd9 || p > 4'd9) begin
            res = 2'b11;
        end else if (n == p) begin
            res = 2'b00;
        end else if (n == up) begin
            res = 2'b01;
        end else if (n == down) begin
            res = 2'b10;
        end else begin
            res = 2'b11;
        end
        return res;
    endfunction

    logic [14:0]      in_q;
    logic [14:0]      in_dly_q;
    logic [CntW-1:0]  stable_q;
    logic [CntW-1:0]  stable_d;
    logic [IdleW-1:0] idle_q;
    logic [IdleW-1:0] idle_d;
    logic [7:0]       seen_q;
    logic [7:0]       seen_d;
    logic [31:0]      shadow_q;
    logic [31:0]      shadow_d;
    logic [31:0]      digits_q;
    logic [31:0]      digits_d;
    logic [7:0]       valid_q;
    logic [7:0]       valid_d;
    logic             frame_done_q;
    logic             frame_done_d;
    logic [1:0]       dir_q;
    logic [1:0]       dir_d;
    logic             seg_err_q;
    logic             seg_err_d;
    logic             stale_q;
    logic             stale_d;

    logic       in_same;
    logic       capture;
    logic [7:0] an_low;
    logic       an_none;
    logic       an_multi;
    logic [2:0] an_idx;
    logic [4:0] dec;
    logic       cap_valid;
    logic       cap_multi;

    // Debounce: capture fires only on the edge where the stable count reaches SETTLE.
    always_comb begin
        in_same = (in_q == in_dly_q);
        if (!in_same) begin
            stable_d = '0;
        end else if (stable_q == SettleMax) begin
            stable_d = stable_q;
        end else begin
            stable_d = stable_q + 1'b1;
        end
        capture = in_same && (stable_q == SettleLast);
    end

    always_comb begin
        an_low   = ~in_q[7:0];
        an_none  = (an_low == 8'h00);
        an_multi = ((an_low & (an_low - 8'd1)) != 8'h00);
        an_idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (an_low[k]) begin
                an_idx = 3'(k);
            end
        end
        dec       = decode_seg(in_q[14:8]);
        cap_valid = capture && !an_none && !an_multi;
        cap_multi = capture && an_multi;
    end

    always_comb begin
        seen_d       = seen_q;
        shadow_d     = shadow_q;
        digits_d     = digits_q;
        valid_d      = valid_q;
        dir_d        = dir_q;
        stale_d      = stale_q;
        frame_done_d = 1'b0;
        seg_err_d    = cap_multi || (cap_valid && dec[4]);

        if (cap_valid) begin
            idle_d = '0;
        end else if (idle_q == IdleMax) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + 1'b1;
        end

        // A capture always beats a coincident timeout.
        if (cap_valid) begin
            if (seen_q[an_idx]) begin
                digits_d     = shadow_q;
                valid_d      = seen_q;
                frame_done_d = 1'b1;
                stale_d      = 1'b0;
                dir_d        = trend(shadow_q[3:0], digits_q[3:0], seen_q[0] && valid_q[0]);
                seen_d       = 8'h01 << an_idx;
            end else begin
                seen_d[an_idx] = 1'b1;
            end
            shadow_d[{an_idx, 2'b00} +: 4] = dec[3:0];
        end else if (idle_d == IdleMax) begin
            stale_d = 1'b1;
            valid_d = '0;
            seen_d  = '0;
            dir_d   = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q         <= '0;
            in_dly_q     <= '0;
            stable_q     <= '0;
            idle_q       <= '0;
            seen_q       <= '0;
            shadow_q     <= '0;
            digits_q     <= '0;
            valid_q      <= '0;
            frame_done_q <= 1'b0;
            dir_q        <= 2'b00;
            seg_err_q    <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            in_q         <= {seg_in, an_in};
            in_dly_q     <= in_q;
            stable_q     <= stable_d;
            idle_q       <= idle_d;
            seen_q       <= seen_d;
            shadow_q     <= shadow_d;
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            dir_q        <= dir_d;
            seg_err_q    <= seg_err_d;
            stale_q      <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign dir         = dir_q;
    assign seg_err     = seg_err_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: the stimulus feeds a digit-level reference model that queues expected
// frames and error pulses; a monitor pops and compares them as the decoder reports.
module tb_seg_scan_decoder;

    localparam int unsigned SETTLE  = 4;
    localparam int unsigned TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg_in = 7'h7F;
    logic [7:0]  an_in = 8'hFF;
    logic [31:0] digits;
    logic [7:0]  digit_valid;
    logic        frame_done;
    logic [1:0]  dir;
    logic        seg_err;
    logic        stale;

    seg_scan_decoder #(
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .dir         (dir),
        .seg_err     (seg_err),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int seg_err_seen = 0;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  valid;
        logic [1:0]  dir;
        int          cyc;
    } frame_t;

    frame_t     fq[$];
    int         sq[$];
    logic [1:0] dir_log[$];

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic [3:0]  m_shadow [8];
    logic [7:0]  m_seen;
    logic [7:0]  m_valid;
    logic [31:0] m_pub;
    logic [14:0] last_pat = 15'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ol(input int k);
        return ~(8'h01 << k);
    endfunction

    task automatic model_reset();
        m_seen  = '0;
        m_valid = '0;
        m_pub   = '0;
        for (int k = 0; k < 8; k++) m_shadow[k] = 4'h0;
    endtask

    // Reference: a pattern held for at least SETTLE+1 cycles is seen once, SETTLE+2 edges
    // after it is first driven.
    task automatic model_item(input logic [6:0] s, input logic [7:0] a, input int n);
        logic [7:0] low;
        int         ones;
        int         k;
        int         v;
        int         nd;
        int         pd;
        int         exp_cyc;
        frame_t     f;
        if (n < int'(SETTLE) + 1) return;
        exp_cyc = cyc + int'(SETTLE) + 2;
        low  = ~a;
        ones = $countones(low);
        if (ones == 0) return;
        if (ones > 1) begin
            sq.push_back(exp_cyc);
            return;
        end
        k = 0;
        for (int i = 0; i < 8; i++) if (low[i]) k = i;
        v = 14;
        for (int d = 0; d < 10; d++) if (s == seg_tab[d]) v = d;
        if (s == 7'h7F) v = 15;
        if (v == 14) sq.push_back(exp_cyc);
        if (m_seen[k]) begin
            for (int i = 0; i < 8; i++) f.digits[i*4 +: 4] = m_shadow[i];
            f.valid = m_seen;
            f.cyc   = exp_cyc;
            nd = int'(m_shadow[0]);
            pd = int'(m_pub[3:0]);
            if (!(m_valid[0] && m_seen[0]) || nd > 9 || pd > 9) f.dir = 2'b11;
            else if (nd == pd)                                 f.dir = 2'b00;
            else if (nd == (pd + 1) % 10)                      f.dir = 2'b01;
            else if (nd == (pd + 9) % 10)                      f.dir = 2'b10;
            else                                               f.dir = 2'b11;
            fq.push_back(f);
            m_pub   = f.digits;
            m_valid = m_seen;
            m_seen  = '0;
        end
        m_seen[k]   = 1'b1;
        m_shadow[k] = 4'(v);
    endtask

    task automatic apply(input logic [6:0] s, input logic [7:0] a, input int n);
        seg_in   = s;
        an_in    = a;
        last_pat = {s, a};
        model_item(s, a, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [15:0] val, input int n);
        for (int a = 0; a < 4; a++) apply(seg_tab[val[a*4 +: 4]], ol(a), n);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_digits"}, digits, 32'h0);
        check({tag, "_valid"}, {24'h0, digit_valid}, 32'h0);
        check({tag, "_frame_done"}, {31'h0, frame_done}, 32'h0);
        check({tag, "_dir"}, {30'h0, dir}, 32'h0);
        check({tag, "_seg_err"}, {31'h0, seg_err}, 32'h0);
        check({tag, "_stale"}, {31'h0, stale}, 32'h0);
    endtask

    always @(negedge clk) begin
        frame_t f;
        int     e;
        if (!rst) begin
            if (frame_done) begin
                if (fq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_done: pulse at cycle %0d, expected no frame", cyc);
                end else begin
                    f = fq.pop_front();
                    check("frame_cycle", cyc, f.cyc);
                    check("frame_digits", digits, f.digits);
                    check("frame_valid", {24'h0, digit_valid}, {24'h0, f.valid});
                    check("frame_dir", {30'h0, dir}, {30'h0, f.dir});
                    check("frame_stale", {31'h0, stale}, 32'h0);
                end
                dir_log.push_back(dir);
            end
            if (seg_err) begin
                seg_err_seen++;
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL seg_err: pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = sq.pop_front();
                    check("seg_err_cycle", cyc, e);
                end
            end
        end
    end

    initial begin
        logic [6:0] s;
        logic [7:0] a;
        int         n;
        int         r;
        int         k;
        int         e0;

        model_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_vals("reset");
        apply(7'h7F, 8'hFF, 6);

        // Digits 3,2,1,0 on anodes 0..3, then anode 0 again closes the frame.
        dir_log.delete();
        scan(16'h0123, 50);
        apply(seg_tab[3], ol(0), 50);
        apply(7'h7F, 8'hFF, 10);
        check("plan_frames", dir_log.size(), 1);
        check("plan_dir", {30'h0, dir}, 32'h3);
        check("plan_digits", {16'h0, digits[15:0]}, 32'h0123);
        check("plan_valid", {24'h0, digit_valid}, 32'h0F);

        // Reset in the middle of a partial frame.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_reset_vals("rst_mid");
        apply(7'h7F, 8'hFF, 6);

        // Counting up 8 -> 9 -> 0.
        dir_log.delete();
        scan(16'h0058, 20);
        scan(16'h0059, 20);
        scan(16'h0060, 20);
        apply(seg_tab[0], ol(0), 20);
        apply(7'h7F, 8'hFF, 10);
        check("up_frames", dir_log.size(), 3);
        check("up_dirs", {26'h0, dir_log[0], dir_log[1], dir_log[2]}, 32'b11_01_01);
        check("up_first_valid_after_rst", {24'h0, digit_valid}, 32'h0F);

        // Long idle goes stale; published digits survive.
        apply(7'h7F, 8'hFF, int'(TIMEOUT) + 10);
        @(negedge clk);
        check("timeout_stale", {31'h0, stale}, 32'h1);
        check("timeout_valid", {24'h0, digit_valid}, 32'h0);
        check("timeout_dir", {30'h0, dir}, 32'h0);
        check("timeout_digits", digits, 32'h0000_0060);
        m_seen  = '0;
        m_valid = '0;
        @(posedge clk);
        #1;

        // Counting down 1 -> 0 -> 9.
        dir_log.delete();
        scan(16'h0021, 20);
        scan(16'h0020, 20);
        scan(16'h0019, 20);
        apply(seg_tab[8], ol(0), 20);
        apply(7'h7F, 8'hFF, 10);
        check("down_frames", dir_log.size(), 3);
        check("down_dirs", {26'h0, dir_log[0], dir_log[1], dir_log[2]}, 32'b11_10_10);
        check("stale_cleared", {31'h0, stale}, 32'h0);

        // Short glitch on anode 5 must not be captured.
        e0 = seg_err_seen;
        apply(seg_tab[7], ol(4), 20);
        apply(7'h24, ol(5), 2);
        apply(seg_tab[7], ol(4), 20);
        apply(seg_tab[5], ol(6), 20);
        apply(seg_tab[1], ol(4), 20);
        check("glitch_valid", {24'h0, digit_valid}, 32'h50);
        check("glitch_nibble5", {28'h0, digits[23:20]}, 32'h0);
        check("glitch_no_seg_err", seg_err_seen - e0, 0);

        // Two anodes low, then an unknown segment pattern stored as E.
        e0 = seg_err_seen;
        apply(seg_tab[0], 8'hFC, 10);
        apply(7'h55, ol(2), 10);
        apply(seg_tab[3], ol(2), 10);
        check("err_pulses", seg_err_seen - e0, 2);
        check("err_nibble2", {28'h0, digits[11:8]}, 32'hE);
        check("err_valid", {24'h0, digit_valid}, 32'h14);

        // A long hold captures exactly once.
        apply(seg_tab[6], ol(7), 150);
        apply(seg_tab[2], ol(1), 10);
        apply(seg_tab[4], ol(7), 10);
        check("hold_valid", {24'h0, digit_valid}, 32'h86);

        // Random traffic; every third item is a settled legal digit so idle never expires.
        for (int i = 0; i < 150; i++) begin
            do begin
                r = int'($urandom_range(0, 9));
                k = int'($urandom_range(0, 7));
                if (i % 3 == 0 || r < 6) begin
                    s = seg_tab[$urandom_range(0, 9)];
                    a = ol(k);
                end else if (r == 6) begin
                    s = 7'h7F;
                    a = ol(k);
                end else if (r == 7) begin
                    s = 7'($urandom);
                    a = ol(k);
                end else if (r == 8) begin
                    s = seg_tab[$urandom_range(0, 9)];
                    a = ol(k) & ol((k + 1 + int'($urandom_range(0, 6))) % 8);
                end else begin
                    s = 7'($urandom);
                    a = 8'hFF;
                end
                n = (i % 3 == 0) ? int'($urandom_range(SETTLE + 1, 20))
                                 : int'($urandom_range(1, 20));
            end while ({s, a} == last_pat);
            apply(s, a, n);
        end

        apply(7'h7F, 8'hFF, int'(SETTLE) + 4);
        check("frames_outstanding", fq.size(), 0);
        check("seg_err_outstanding", sq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
